// File: rtl/argmax_seq_ctrl.sv
// Serial argmax over the output-layer score buffer: one read per cycle, running max plus class tag.
// Latency: start edge to res_valid is N_CLASS+RD_LAT+1 edges, or k+RD_LAT+2 when class k saturates.
// Backpressure: the result holds in DONE until res_ready; start is ignored outside IDLE.
module argmax_seq_ctrl #(
  parameter int N_CLASS = 10,
  parameter int DW      = 8,
  parameter int AW      = 4,
  parameter int RD_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_class,
  output logic [DW-1:0] res_score,
  output logic          res_sat
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [DW-1:0] SAT_CODE = {1'b1, {(DW-1){1'b0}}};
  localparam logic [AW-1:0] LAST_CLS = AW'(N_CLASS - 1);

  state_t          state_q;
  logic            rd_en_q;
  logic [AW-1:0]   rd_addr_q;
  logic            busy_q;
  logic            res_valid_q;
  logic [AW-1:0]   res_class_q;
  logic [DW-1:0]   res_score_q;
  logic            res_sat_q;

  // Read-valid pipe: entry RD_LAT-1 lines up with rd_data.
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [AW-1:0]     pipe_tag_q [RD_LAT];

  // Captured score waiting for comparison on the following edge.
  logic            cmp_vld_q;
  logic [DW-1:0]   cmp_dat_q;
  logic [AW-1:0]   cmp_cls_q;

  // Running maximum of the current scan.
  logic [DW-1:0]   max_q, max_d;
  logic [AW-1:0]   cls_q, cls_d;

  logic            head_vld;
  logic            head_sat;
  logic            take_new;
  logic            scan_end;

  // Map sign-magnitude scores onto an unsigned rank: saturation on top,
  // positives above all negatives, negatives reversed by magnitude.
  function automatic logic [DW:0] rank_f(input logic [DW-1:0] s);
    logic [DW:0] r;
    if (s == SAT_CODE)  r = {1'b1, {DW{1'b0}}};
    else if (!s[DW-1])  r = {2'b01, s[DW-2:0]};
    else                r = {2'b00, ~s[DW-2:0]};
    return r;
  endfunction

  // Compare captured score against running max; strict greater keeps the lower class on ties.
  always_comb begin
    head_vld = pipe_vld_q[RD_LAT-1];
    head_sat = head_vld && (rd_data == SAT_CODE);
    take_new = cmp_vld_q && ((cmp_cls_q == '0) || (rank_f(cmp_dat_q) > rank_f(max_q)));
    max_d    = take_new ? cmp_dat_q : max_q;
    cls_d    = take_new ? cmp_cls_q : cls_q;
    scan_end = cmp_vld_q && ((cmp_dat_q == SAT_CODE) || (cmp_cls_q == LAST_CLS));
  end

  // Sequencer, read pipe, compare stage and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_score_q <= '0;
      res_sat_q   <= 1'b0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_tag_q[i] <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_dat_q   <= '0;
      cmp_cls_q   <= '0;
      max_q       <= '0;
      cls_q       <= '0;
    end else if (abort) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      pipe_vld_q  <= '0;
      cmp_vld_q   <= 1'b0;
    end else begin
      pipe_vld_q[0] <= rd_en_q;
      pipe_tag_q[0] <= rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
      cmp_vld_q <= head_vld;
      if (head_vld) begin
        cmp_dat_q <= rd_data;
        cmp_cls_q <= pipe_tag_q[RD_LAT-1];
      end
      if (cmp_vld_q) begin
        max_q <= max_d;
        cls_q <= cls_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FETCH;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        FETCH, DRAIN: begin
          if (scan_end) begin
            state_q     <= DONE;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b1;
            res_class_q <= cls_d;
            res_score_q <= max_d;
            res_sat_q   <= (max_d == SAT_CODE);
          end else if (head_sat) begin
            // Saturation arriving: stop issuing and drop anything still in flight.
            state_q    <= DRAIN;
            rd_en_q    <= 1'b0;
            pipe_vld_q <= '0;
          end else if (state_q == FETCH) begin
            if (rd_addr_q == LAST_CLS) begin
              state_q <= DRAIN;
              rd_en_q <= 1'b0;
            end else begin
              rd_addr_q <= rd_addr_q + AW'(1);
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_score = res_score_q;
  assign res_sat   = res_sat_q;

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Bench for argmax_seq_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share stimulus,
// each fed by its own score-buffer model; results are compared against a rank-based
// reference computed directly from the scoring rules.
module tb_argmax_seq_ctrl;
  localparam int NC = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       res_ready = 1'b0;
  logic       rd_en     [2];
  logic [3:0] rd_addr   [2];
  logic [7:0] rd_data   [2];
  logic       busy      [2];
  logic       res_valid [2];
  logic [3:0] res_class [2];
  logic [7:0] res_score [2];
  logic       res_sat   [2];

  logic [7:0] mem [NC];
  int n_tests = 0;
  int n_fail  = 0;
  int gcyc    = 0;
  int iss_n   [2];
  int iss_cyc [2];
  bit iss_ok  [2];

  always #5 clk = ~clk;

  argmax_seq_ctrl #(.N_CLASS(10), .DW(8), .AW(4), .RD_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .busy(busy[0]), .res_valid(res_valid[0]), .res_ready(res_ready),
    .res_class(res_class[0]), .res_score(res_score[0]), .res_sat(res_sat[0]));

  argmax_seq_ctrl #(.N_CLASS(10), .DW(8), .AW(4), .RD_LAT(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .busy(busy[1]), .res_valid(res_valid[1]), .res_ready(res_ready),
    .res_class(res_class[1]), .res_score(res_score[1]), .res_sat(res_sat[1]));

  // Score buffers: valid data RD_LAT cycles after the strobe, random junk otherwise.
  logic       en3_a, en3_b;
  logic [3:0] ad3_a, ad3_b;
  always @(posedge clk) begin
    rd_data[0] <= (rd_en[0] === 1'b1 && rd_addr[0] < NC) ? mem[rd_addr[0]] : 8'($urandom);
    en3_a <= rd_en[1];
    ad3_a <= rd_addr[1];
    en3_b <= en3_a;
    ad3_b <= ad3_a;
    rd_data[1] <= (en3_b === 1'b1 && ad3_b < NC) ? mem[ad3_b] : 8'($urandom);
  end

  // Read-issue monitor: addresses must run 0,1,2.. on consecutive cycles.
  always @(posedge clk) begin
    gcyc++;
    for (int j = 0; j < 2; j++) begin
      if (rd_en[j] === 1'b1) begin
        if (int'(rd_addr[j]) != iss_n[j] || (iss_n[j] > 0 && gcyc != iss_cyc[j] + 1))
          iss_ok[j] = 1'b0;
        iss_n[j]++;
        iss_cyc[j] = gcyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int key_of(input logic [7:0] v);
    if (v == 8'h80) return 1000;
    if (v[7] == 1'b0) return 500 + int'(v[6:0]);
    return 500 - int'(v[6:0]);
  endfunction

  // Reference: first-best scan, stopping at the first saturation code.
  task automatic model(output int cls, output int sc, output int sat, output int satk);
    cls = 0;
    satk = -1;
    for (int i = 0; i < NC; i++) begin
      if (i == 0 || key_of(mem[i]) > key_of(mem[cls])) cls = i;
      if (mem[i] == 8'h80) begin
        satk = i;
        break;
      end
    end
    sc  = int'(mem[cls]);
    sat = (mem[cls] == 8'h80) ? 1 : 0;
  endtask

  task automatic clr_mon();
    for (int j = 0; j < 2; j++) begin
      iss_n[j] = 0;
      iss_ok[j] = 1'b1;
      iss_cyc[j] = 0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s.rd_en%0d", tag, j), 32'(rd_en[j]), 0);
      chk($sformatf("%s.rd_addr%0d", tag, j), 32'(rd_addr[j]), 0);
      chk($sformatf("%s.busy%0d", tag, j), 32'(busy[j]), 0);
      chk($sformatf("%s.res_valid%0d", tag, j), 32'(res_valid[j]), 0);
      chk($sformatf("%s.res_cls_scr_sat%0d", tag, j),
          {19'd0, res_sat[j], res_class[j], res_score[j]}, 0);
    end
  endtask

  task automatic run_scan(input string tag, input bit consume);
    int ecls, esc, esat, satk, n, lat, elat, eiss, lastk;
    int got[2];
    model(ecls, esc, esat, satk);
    clr_mon();
    got[0] = 0;
    got[1] = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while ((got[0] == 0 || got[1] == 0) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      for (int j = 0; j < 2; j++) begin
        if (n == 1) chk($sformatf("%s.busy_on%0d", tag, j), 32'(busy[j]), 1);
        if (res_valid[j] === 1'b1 && got[j] == 0) got[j] = n;
      end
    end
    for (int j = 0; j < 2; j++) begin
      lat   = (j == 0) ? 1 : 3;
      lastk = (satk + lat < NC - 1) ? satk + lat : NC - 1;
      elat  = (satk >= 0) ? satk + lat + 2 : NC + lat + 1;
      eiss  = (satk >= 0) ? lastk + 1 : NC;
      chk($sformatf("%s.latency_L%0d", tag, lat), 32'(got[j]), 32'(elat));
      chk($sformatf("%s.class_L%0d", tag, lat), 32'(res_class[j]), 32'(ecls));
      chk($sformatf("%s.score_L%0d", tag, lat), 32'(res_score[j]), 32'(esc));
      chk($sformatf("%s.sat_L%0d", tag, lat), 32'(res_sat[j]), 32'(esat));
      chk($sformatf("%s.busy_done_L%0d", tag, lat), 32'(busy[j]), 0);
      chk($sformatf("%s.reads_L%0d", tag, lat), 32'(iss_n[j]), 32'(eiss));
      chk($sformatf("%s.read_seq_L%0d", tag, lat), 32'(iss_ok[j]), 1);
    end
    if (consume) begin
      @(negedge clk) res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      for (int j = 0; j < 2; j++)
        chk($sformatf("%s.consumed%0d", tag, j), 32'(res_valid[j]), 0);
    end
  endtask

  initial begin
    int ecls, esc, esat, satk;
    bit ok [2];
    rst_n = 1'b1;
    clr_mon();
    #1 rst_n = 1'b0;
    #20;
    chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    mem = '{8'h05, 8'h12, 8'h7F, 8'h01, 8'h00, 8'h30, 8'h02, 8'h11, 8'h7E, 8'h03};
    run_scan("basic", 1'b1);
    mem = '{8'h85, 8'h81, 8'h90, 8'hFF, 8'h82, 8'h83, 8'h84, 8'h86, 8'h87, 8'h88};
    run_scan("allneg", 1'b1);
    mem = '{8'h10, 8'h10, 8'h10, 8'h20, 8'h10, 8'h10, 8'h10, 8'h20, 8'h10, 8'h10};
    run_scan("tie", 1'b1);
    mem = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    run_scan("sat4", 1'b1);

    // Result held under backpressure; a start pulse in DONE must be ignored.
    mem = '{8'h05, 8'h12, 8'h7F, 8'h01, 8'h00, 8'h30, 8'h02, 8'h11, 8'h7E, 8'h03};
    model(ecls, esc, esat, satk);
    run_scan("hold", 1'b0);
    ok[0] = 1'b1;
    ok[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      for (int j = 0; j < 2; j++)
        if (res_valid[j] !== 1'b1 || int'(res_class[j]) != ecls || int'(res_score[j]) != esc ||
            busy[j] !== 1'b0 || rd_en[j] !== 1'b0)
          ok[j] = 1'b0;
    end
    for (int j = 0; j < 2; j++) chk($sformatf("hold.stable%0d", j), 32'(ok[j]), 1);
    @(negedge clk) res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    for (int j = 0; j < 2; j++) chk($sformatf("hold.release%0d", j), 32'(res_valid[j]), 0);
    mem = '{8'h10, 8'h10, 8'h10, 8'h20, 8'h10, 8'h10, 8'h10, 8'h20, 8'h10, 8'h10};
    run_scan("after_hold", 1'b1);

    // start together with res_ready in DONE: consume only.
    run_scan("start_ready", 1'b0);
    @(negedge clk);
    start = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("start_ready.valid%0d", j), 32'(res_valid[j]), 0);
      chk($sformatf("start_ready.busy%0d", j), 32'(busy[j]), 0);
      chk($sformatf("start_ready.rd_en%0d", j), 32'(rd_en[j]), 0);
    end

    // Abort in the 5th FETCH cycle.
    mem = '{8'h05, 8'h12, 8'h7F, 8'h01, 8'h00, 8'h30, 8'h02, 8'h11, 8'h7E, 8'h03};
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("abort.rd_en%0d", j), 32'(rd_en[j]), 0);
      chk($sformatf("abort.busy%0d", j), 32'(busy[j]), 0);
    end
    clr_mon();
    ok[0] = 1'b1;
    ok[1] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) if (res_valid[j] !== 1'b0) ok[j] = 1'b0;
    end
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("abort.no_valid%0d", j), 32'(ok[j]), 1);
      chk($sformatf("abort.no_reads%0d", j), 32'(iss_n[j]), 0);
    end
    mem = '{8'h85, 8'h81, 8'h90, 8'hFF, 8'h82, 8'h83, 8'h84, 8'h86, 8'h87, 8'h88};
    run_scan("after_abort", 1'b1);

    // Asynchronous reset while both instances are draining.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    for (int j = 0; j < 2; j++) chk($sformatf("drain.busy%0d", j), 32'(busy[j]), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok[0] = 1'b1;
    ok[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) if (res_valid[j] !== 1'b0 || busy[j] !== 1'b0) ok[j] = 1'b0;
    end
    for (int j = 0; j < 2; j++) chk($sformatf("midreset.quiet%0d", j), 32'(ok[j]), 1);
    mem = '{8'h05, 8'h12, 8'h7F, 8'h01, 8'h00, 8'h30, 8'h02, 8'h11, 8'h7E, 8'h03};
    run_scan("after_reset", 1'b1);

    // Randomized scans: mixed signs, small-range ties, occasional saturation.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NC; i++) begin
        case ($urandom_range(0, 3))
          0:       mem[i] = 8'($urandom);
          1:       mem[i] = 8'($urandom_range(0, 3));
          2:       mem[i] = {1'b1, 7'($urandom_range(1, 4))};
          default: mem[i] = 8'($urandom_range(0, 127));
        endcase
      end
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, NC - 1)] = 8'h80;
      run_scan($sformatf("rand%0d", t), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/argmax_seq_ctrl.md
Name: argmax_seq_ctrl

Overview:
- Sequencer for the output-layer classification step of the handwritten-digit DNN.
- After the last layer has written its N_CLASS scores into the output score buffer, this block reads the scores back one per cycle and tracks the running maximum and its class index.
- It returns the winning digit to the display/UART side over a valid/ready handshake.
- It replaces the flat 10-way combinational max tree with a pipelined serial scan, and supports early termination on the saturation code.

Parameters:
- N_CLASS, 10, number of scores scanned, at addresses 0..N_CLASS-1.
- DW, 8, score width; sign-magnitude encoding.
- AW, 4, score-buffer address width; must satisfy 2^AW >= N_CLASS.
- RD_LAT, 1, fixed score-buffer read latency in cycles, from rd_en to rd_data valid; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to classify; honoured only in IDLE.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- rd_en  out  1  score-buffer read strobe.
- rd_addr  out  AW  score-buffer address; address k = class k.
- rd_data  in  DW  score-buffer read data, valid RD_LAT cycles after rd_en.
- busy  out  1  high in FETCH or DRAIN.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_class  out  AW  winning class index.
- res_score  out  DW  winning score.
- res_sat  out  1  winner is the saturation code 0x80.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rd_en=0; rd_addr=0; busy=0; res_valid=0; res_class=0; res_score=0; res_sat=0; all internal counters and the read-valid pipe cleared.
- Score ordering, highest to lowest:
  - 0x80 (saturation) is above everything.
  - Positive values (bit7=0) rank by bits[6:0].
  - Negative values (bit7=1, mag!=0) rank below all positives; larger magnitude is smaller.
  - Ties keep the earlier (lower) class.
- The first compared score (class 0) unconditionally loads the running max.
- States:
  - IDLE: start=1 → FETCH, issue counter=0. start is ignored in every other state.
  - FETCH: rd_en=1, rd_addr=issue counter, one address per cycle. After issuing N_CLASS-1 → DRAIN.
  - DRAIN: rd_en=0. Waits for outstanding data. When the last score (class N_CLASS-1) is compared → DONE.
  - DONE: res_valid=1 and the result outputs are stable. res_ready=1 → IDLE, res_valid=0 next cycle. res_valid holds indefinitely until res_ready.
- Comparison occurs on the cycle rd_data is valid, tracked by an RD_LAT-deep valid/class-tag shift pipe.
- Latency: start sampled at edge 0 → res_valid high after edge N_CLASS+RD_LAT+1 (12 cycles at the defaults).
- Early termination:
  - When a compared score equals 0x80, load it as the max, set res_sat, and go to DONE on the next edge.
  - Any in-flight read data is discarded (the valid pipe is flushed).
  - No further rd_en is issued.
- abort: in any state → IDLE next edge. rd_en drops, res_valid clears, and the pipe is flushed. abort has priority over start, res_ready and comparison.
- start and res_ready in the same cycle while in DONE: the result is consumed, start is ignored, and the block returns to IDLE.
- Reset mid-scan: immediate return to reset values; no partial result is ever presented.
- Result registers update only while scanning. Their values are undefined-free: they keep the last completed result while in IDLE.

Test Plan:
- Scores [0x05,0x12,0x7F,0x01,0x00,0x30,0x02,0x11,0x7E,0x03], RD_LAT=1 → res_class=2, res_score=0x7F, res_sat=0, res_valid 12 cycles after start, rd_addr 0..9 on consecutive cycles.
- All negative [0x85,0x81,0x90,0xFF,0x82,0x83,0x84,0x86,0x87,0x88] → res_class=1, res_score=0x81. Tie test [0x20 at class 3 and class 7, others 0x10] → res_class=3.
- 0x80 at class 4, 0x7F elsewhere → res_class=4, res_sat=1. rd_en is never asserted for addr ≥ 5+RD_LAT and classes 5..9 are never compared. res_valid arrives at edge 4+RD_LAT+2 after start.
- res_ready held low for 20 cycles in DONE → outputs stable, busy=0, and a start pulse during this window is ignored. Then res_ready=1 → IDLE; a new start then rescans correctly.
- abort asserted at the 5th FETCH cycle → IDLE next edge, rd_en=0, res_valid never rises. A rescan afterwards gives the correct result. Repeat with rst_n pulsed low mid-DRAIN → all outputs at reset values asynchronously.
- RD_LAT=3 with the scores from the first scenario → same result, res_valid 14 cycles after start.
